dut_readback: RTL and testbench

DUT_READBACK -- requirements
Module: dut_readback

---
 rtl/dut_readback_if.sv | 20 ++
 rtl/dut_readback.sv | 83 ++++++++
 tb/tb_dut_readback.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dut_readback_if.sv
// dut_readback_if: request/result and DUT-probe signals of the bit-serial readback engine.
interface dut_readback_if;
  logic        start;
  logic        abort;
  logic [31:0] operand;
  logic [31:0] dut_input;
  logic [31:0] dut_signal_select;
  logic        dut_output;
  logic        busy;
  logic        done;
  logic [31:0] result;
  modport master (
    output start, abort, operand, dut_output,
    input  dut_input, dut_signal_select, busy, done, result
  );
  modport slave (
    input  start, abort, operand, dut_output,
    output dut_input, dut_signal_select, busy, done, result
  );
endinterface

// File: rtl/dut_readback.sv
// dut_readback: applies an operand to a DUT and rebuilds its 32-bit result one selected bit at a time.
module dut_readback #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  dut_readback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] work_q, work_d;
  logic [31:0] in_q, in_d;
  logic [31:0] res_q, res_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      work_q  <= '0;
      in_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      in_q    <= in_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // Abort wins over the sampling edge; the working word is only published from DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    work_d  = work_q;
    in_d    = in_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SETTLE;
        in_d    = bus.operand;
        sel_d   = '0;
        cnt_d   = '0;
        work_d  = '0;
      end
      SETTLE: if (bus.abort) begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        work_d[sel_q] = bus.dut_output;
        cnt_d         = '0;
        state_d       = (sel_q == 5'd31) ? DONE : SETTLE;
        sel_d         = (sel_q == 5'd31) ? sel_q : sel_q + 5'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      DONE: begin
        state_d = IDLE;
        res_d   = work_q;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  assign bus.dut_input         = in_q;
  assign bus.dut_signal_select = {27'b0, sel_q};
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.result            = res_q;
endmodule

// File: tb/tb_dut_readback.sv
// tb_dut_readback: drives two readback engines (settle 2 and 1) against a behavioural 16x16 multiplier DUT.
module tb_dut_readback;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [31:0] res0;
  dut_readback_if a();
  dut_readback_if b();
  dut_readback #(.SETTLE_CYCLES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  dut_readback #(.SETTLE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  function automatic logic [31:0] mul(input logic [31:0] x);
    return {16'b0, x[31:16]} * {16'b0, x[15:0]};
  endfunction
  logic [31:0] pa, pb;
  assign pa = mul(a.dut_input);
  assign pb = mul(b.dut_input);
  assign a.dut_output = pa[a.dut_signal_select[4:0]];
  assign b.dut_output = pb[b.dut_signal_select[4:0]];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string who, input logic [31:0] di, input logic [31:0] sel,
                          input logic bz, input logic dn, input logic [31:0] rs);
    chk({who, " dut_input"}, di, 32'h0);
    chk({who, " select"}, sel, 32'h0);
    chk({who, " busy"}, {31'b0, bz}, 32'h0);
    chk({who, " done"}, {31'b0, dn}, 32'h0);
    chk({who, " result"}, rs, 32'h0);
  endtask
  // ab: cycle abort is held high (-1 none), rs: cycle start is re-pulsed (-1 none)
  task automatic sweep0(input logic [31:0] op, input int ab, input int rs);
    logic [31:0] exp, prev;
    bit abt;
    exp  = mul(op);
    prev = res0;
    abt  = (ab >= 0 && ab < 64);
    @(negedge clk);
    a.start = 1'b1;
    a.operand = op;
    @(posedge clk);
    #1;
    a.start = 1'b0;
    a.operand = $urandom;
    for (int c = 0; c <= 66; c++) begin
      @(negedge clk);
      if (abt && c > ab) chk($sformatf("sel c%0d", c), a.dut_signal_select, 32'h0);
      else if (c <= 64) chk($sformatf("sel c%0d", c), a.dut_signal_select, (c < 64) ? 32'(c / 2) : 32'd31);
      if (c <= (abt ? ab : 64)) chk($sformatf("dut_input c%0d", c), a.dut_input, op);
      chk($sformatf("busy c%0d", c), {31'b0, a.busy}, {31'b0, abt ? (c <= ab) : (c <= 64)});
      chk($sformatf("done c%0d", c), {31'b0, a.done}, {31'b0, !abt && c == 65});
      chk($sformatf("result c%0d", c), a.result, (!abt && c >= 65) ? exp : prev);
      a.start = (c == rs);
      if (c == rs) a.operand = 32'h1234_5678;
      a.abort = (c == ab);
    end
    a.start = 1'b0;
    a.abort = 1'b0;
    if (!abt) res0 = exp;
  endtask
  initial begin
    logic [31:0] opk, exp;
    tests = 0;
    fails = 0;
    res0  = 32'h0;
    rst_n = 1'b0;
    a.start = 1'b0; a.abort = 1'b0; a.operand = 32'h0;
    b.start = 1'b0; b.abort = 1'b0; b.operand = 32'h0;
    #1;
    chk_zero("reset u0", a.dut_input, a.dut_signal_select, a.busy, a.done, a.result);
    chk_zero("reset u1", b.dut_input, b.dut_signal_select, b.busy, b.done, b.result);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep0(32'h0003_0005, -1, -1);
    sweep0(32'hFFFF_FFFF, -1, -1);
    sweep0(32'h0003_0005, -1, 10);
    sweep0($urandom, 20, -1);
    sweep0($urandom, -1, -1);
    sweep0($urandom, 64, -1);
    for (int i = 0; i < 3; i++) sweep0($urandom, -1, -1);
    @(negedge clk);
    a.start = 1'b1;
    a.operand = $urandom;
    @(posedge clk);
    #1;
    a.start = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset u0", a.dut_input, a.dut_signal_select, a.busy, a.done, a.result);
    @(negedge clk);
    rst_n = 1'b1;
    res0 = 32'h0;
    sweep0(32'h0002_0002, -1, -1);
    chk("mult 2x2", res0, 32'h0000_0004);
    @(negedge clk);
    opk = $urandom;
    b.start = 1'b1;
    b.operand = opk;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      exp = mul(opk);
      for (int c = 0; c <= 33; c++) begin
        @(negedge clk);
        chk($sformatf("u1 done r%0d c%0d", k, c), {31'b0, b.done}, {31'b0, c == 33});
        chk($sformatf("u1 busy r%0d c%0d", k, c), {31'b0, b.busy}, {31'b0, c <= 32});
        if (c == 33) begin
          chk($sformatf("u1 result r%0d", k), b.result, exp);
          opk = $urandom;
          b.operand = opk;
        end
      end
    end
    b.start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
